// File: rtl/pc_npc_unit_pkg.sv
// Shared pipeline definitions for the fetch PC / next-PC unit.
package pc_npc_unit_pkg;

  localparam int unsigned PcWDefault = 9;

  typedef enum logic [1:0] {
    SelBranch = 2'b00,
    SelJump   = 2'b01,
    SelReg    = 2'b10,
    SelRsvd   = 2'b11
  } redirect_sel_e;

  typedef enum logic {
    StIdle    = 1'b0,
    StPending = 1'b1
  } npc_state_e;

endpackage

// File: rtl/pc_npc_unit_if.sv
// Decode-to-fetch redirect bus plus the fetch-address outputs.
interface pc_npc_unit_if #(
  parameter int unsigned PC_W = pc_npc_unit_pkg::PcWDefault
);
  logic            load_enable;
  logic            redirect_valid;
  logic [1:0]      redirect_sel;
  logic [15:0]     imm16;
  logic [25:0]     address_26;
  logic [31:0]     reg_target;
  logic [PC_W-1:0] pc;
  logic [PC_W-1:0] npc;
  logic            pending;
  logic            redirect_taken;
  logic            misalign_err;

  modport master (
    output load_enable, redirect_valid, redirect_sel, imm16, address_26, reg_target,
    input  pc, npc, pending, redirect_taken, misalign_err
  );

  modport slave (
    input  load_enable, redirect_valid, redirect_sel, imm16, address_26, reg_target,
    output pc, npc, pending, redirect_taken, misalign_err
  );
endinterface

// File: rtl/pc_target_calc.sv
// Combinational redirect target computation (branch / jump / register).
module pc_target_calc
  import pc_npc_unit_pkg::*;
#(
  parameter int unsigned PC_W = PcWDefault
) (
  input  logic [PC_W-1:0] pc_i,
  input  logic            redirect_valid_i,
  input  logic [1:0]      redirect_sel_i,
  input  logic [15:0]     imm16_i,
  input  logic [25:0]     address_26_i,
  input  logic [31:0]     reg_target_i,
  output logic [PC_W-1:0] target_o,
  output logic            target_valid_o,
  output logic            misalign_o
);

  redirect_sel_e   sel;
  logic [PC_W-1:0] branch_off;
  logic            unused_bits;

  assign sel        = redirect_sel_e'(redirect_sel_i);
  // Sign-extended word offset, truncated to the address width (modulo arithmetic).
  assign branch_off = PC_W'({{14{imm16_i[15]}}, imm16_i, 2'b00});

  always_comb begin
    target_o       = '0;
    target_valid_o = 1'b0;
    unique case (sel)
      SelBranch: begin
        target_o       = pc_i + branch_off;
        target_valid_o = redirect_valid_i;
      end
      SelJump: begin
        target_o       = {address_26_i[PC_W-3:0], 2'b00};
        target_valid_o = redirect_valid_i;
      end
      SelReg: begin
        target_o       = {reg_target_i[PC_W-1:2], 2'b00};
        target_valid_o = redirect_valid_i;
      end
      default: begin
        target_o       = '0;
        target_valid_o = 1'b0;
      end
    endcase
  end

  assign misalign_o  = redirect_valid_i && (sel == SelReg) && (|reg_target_i[1:0]);
  assign unused_bits = ^{reg_target_i[31:PC_W], address_26_i[25:PC_W-2]};

endmodule

// File: rtl/pc_npc_unit.sv
// Fetch PC / next-PC registers with a one-deep redirect holding FSM for stalls.
module pc_npc_unit
  import pc_npc_unit_pkg::*;
#(
  parameter int unsigned      PC_W     = PcWDefault,
  parameter logic [PC_W-1:0]  RESET_PC = '0
) (
  input  logic         clk,
  input  logic         reset,
  pc_npc_unit_if.slave bus
);

  localparam logic [PC_W-1:0] Four = PC_W'(4);

  npc_state_e      state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [PC_W-1:0] npc_q, npc_d;
  logic [PC_W-1:0] tgt_q, tgt_d;
  logic            taken_q, taken_d;
  logic            mis_q, mis_d;

  logic [PC_W-1:0] target;
  logic            target_valid;
  logic            misalign;

  pc_target_calc #(
    .PC_W (PC_W)
  ) u_target_calc (
    .pc_i             (pc_q),
    .redirect_valid_i (bus.redirect_valid),
    .redirect_sel_i   (bus.redirect_sel),
    .imm16_i          (bus.imm16),
    .address_26_i     (bus.address_26),
    .reg_target_i     (bus.reg_target),
    .target_o         (target),
    .target_valid_o   (target_valid),
    .misalign_o       (misalign)
  );

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    npc_d   = npc_q;
    tgt_d   = tgt_q;
    taken_d = 1'b0;
    mis_d   = mis_q;
    unique case (state_q)
      StIdle: begin
        // Misalignment is only flagged for redirects actually accepted.
        if (target_valid && misalign) begin
          mis_d = 1'b1;
        end
        if (bus.load_enable) begin
          if (target_valid) begin
            pc_d    = target;
            npc_d   = target + Four;
            taken_d = 1'b1;
          end else begin
            pc_d  = npc_q;
            npc_d = npc_q + Four;
          end
        end else if (target_valid) begin
          tgt_d   = target;
          state_d = StPending;
        end
      end
      StPending: begin
        // New redirects are ignored until the captured one is applied.
        if (bus.load_enable) begin
          pc_d    = tgt_q;
          npc_d   = tgt_q + Four;
          taken_d = 1'b1;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      pc_q    <= RESET_PC;
      npc_q   <= RESET_PC + Four;
      tgt_q   <= '0;
      taken_q <= 1'b0;
      mis_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      npc_q   <= npc_d;
      tgt_q   <= tgt_d;
      taken_q <= taken_d;
      mis_q   <= mis_d;
    end
  end

  assign bus.pc             = pc_q;
  assign bus.npc            = npc_q;
  assign bus.pending        = (state_q == StPending);
  assign bus.redirect_taken = taken_q;
  assign bus.misalign_err   = mis_q;

endmodule

// File: tb/tb_pc_npc_unit.sv
// Scoreboard bench: driver pushes model predictions, monitor compares each cycle.
module tb_pc_npc_unit;

  localparam int unsigned PcW     = 9;
  localparam int          AddrMod = 512;
  localparam int          ResetPc = 0;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] npc;
    logic [31:0] pend;
    logic [31:0] taken;
    logic [31:0] mis;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  pc_npc_unit_if #(.PC_W(PcW)) bus ();

  pc_npc_unit #(
    .PC_W     (PcW),
    .RESET_PC (9'd0)
  ) u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int   n_cmp = 0;
  int   n_bad = 0;
  exp_t sb[$];
  exp_t mon_e;

  // Reference model state, plain integers.
  int m_pc, m_npc, m_tgt;
  bit m_pend, m_taken, m_mis;

  function automatic int wrap(input int v);
    return ((v % AddrMod) + AddrMod) % AddrMod;
  endfunction

  task automatic model_step(input bit rst, input bit le, input bit rv, input logic [1:0] sel,
                            input logic [15:0] imm, input logic [25:0] a26,
                            input logic [31:0] rt);
    int t;
    bit v;
    if (rst) begin
      m_pc = ResetPc; m_npc = wrap(ResetPc + 4); m_tgt = 0;
      m_pend = 0; m_taken = 0; m_mis = 0;
      return;
    end
    m_taken = 0;
    if (m_pend) begin
      if (le) begin
        m_pc = m_tgt; m_npc = wrap(m_tgt + 4); m_taken = 1; m_pend = 0;
      end
      return;
    end
    v = rv && (sel != 2'b11);
    case (sel)
      2'b00:   t = wrap(m_pc + int'($signed(imm)) * 4);
      2'b01:   t = wrap(int'(a26) * 4);
      2'b10:   t = int'(rt & 32'h0000_01FC);
      default: t = 0;
    endcase
    if (v && sel == 2'b10 && rt[1:0] != 2'b00) m_mis = 1;
    if (le) begin
      if (v) begin
        m_pc = t; m_npc = wrap(t + 4); m_taken = 1;
      end else begin
        m_pc = m_npc; m_npc = wrap(m_npc + 4);
      end
    end else if (v) begin
      m_tgt = t; m_pend = 1;
    end
  endtask

  task automatic step(input bit rst, input bit le, input bit rv, input logic [1:0] sel,
                      input logic [15:0] imm, input logic [25:0] a26, input logic [31:0] rt);
    exp_t e;
    @(negedge clk);
    reset              = rst;
    bus.load_enable    = le;
    bus.redirect_valid = rv;
    bus.redirect_sel   = sel;
    bus.imm16          = imm;
    bus.address_26     = a26;
    bus.reg_target     = rt;
    model_step(rst, le, rv, sel, imm, a26, rt);
    e.pc = m_pc; e.npc = m_npc; e.pend = 32'(m_pend); e.taken = 32'(m_taken);
    e.mis = 32'(m_mis);
    @(posedge clk);
    sb.push_back(e);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (sb.size() > 0) begin
      mon_e = sb.pop_front();
      chk("pc", 32'(bus.pc), mon_e.pc);
      chk("npc", 32'(bus.npc), mon_e.npc);
      chk("pending", 32'(bus.pending), mon_e.pend);
      chk("redirect_taken", 32'(bus.redirect_taken), mon_e.taken);
      chk("misalign_err", 32'(bus.misalign_err), mon_e.mis);
    end
  end

  initial begin
    reset = 1'b1;
    bus.load_enable = 1'b0; bus.redirect_valid = 1'b0; bus.redirect_sel = 2'b00;
    bus.imm16 = '0; bus.address_26 = '0; bus.reg_target = '0;

    // Reset, then sequential advance: 4, 8, 12, 16.
    step(1, 0, 0, 2'b00, 16'h0, 26'h0, 32'h0);
    repeat (4) step(0, 1, 0, 2'b00, 16'h0, 26'h0, 32'h0);
    // Branch back by two words from 0x010.
    step(0, 1, 1, 2'b00, 16'hFFFE, 26'h0, 32'h0);
    step(0, 1, 0, 2'b00, 16'h0, 26'h0, 32'h0);
    // Jump captured during stall, second redirect ignored, applied on resume.
    step(0, 0, 1, 2'b01, 16'h0, 26'h0000040, 32'h0);
    step(0, 0, 1, 2'b00, 16'h0005, 26'h0, 32'h0);
    step(0, 0, 0, 2'b00, 16'h0, 26'h0, 32'h0);
    step(0, 1, 1, 2'b00, 16'h0005, 26'h0, 32'h0);
    step(0, 1, 0, 2'b00, 16'h0, 26'h0, 32'h0);
    // Misaligned register target, flag sticky.
    step(0, 1, 1, 2'b10, 16'h0, 26'h0, 32'h0000_0103);
    step(0, 1, 1, 2'b11, 16'h0, 26'h0, 32'h0);
    step(0, 1, 0, 2'b00, 16'h0, 26'h0, 32'h0);
    // Wrap from 0x1FC to 0x000.
    step(0, 1, 1, 2'b01, 16'h0, 26'h000007F, 32'h0);
    step(0, 1, 0, 2'b00, 16'h0, 26'h0, 32'h0);
    // Reset while pending discards the captured target.
    step(0, 0, 1, 2'b01, 16'h0, 26'h0000040, 32'h0);
    step(1, 1, 1, 2'b01, 16'h0, 26'h0000010, 32'h0);
    step(0, 1, 0, 2'b00, 16'h0, 26'h0, 32'h0);
    step(0, 1, 0, 2'b00, 16'h0, 26'h0, 32'h0);

    for (int i = 0; i < 400; i++) begin
      logic [31:0] rt;
      rt = $urandom;
      if ($urandom_range(0, 3) != 0) rt[1:0] = 2'b00;
      step(($urandom_range(0, 39) == 0), ($urandom_range(0, 2) != 0),
           ($urandom_range(0, 1) == 1), 2'($urandom_range(0, 3)),
           16'($urandom), 26'($urandom), rt);
    end

    for (int i = 0; i < 10 && sb.size() > 0; i++) @(posedge clk);
    if (sb.size() > 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain: %0d entries left, expected 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
